// File: rtl/ctrl_encode_def.sv
// ctrl_encode_def: shared control encodings for next-PC selection
package ctrl_encode_def;
    typedef enum logic [1:0] {
        NPC_PLUS4    = 2'd0,
        NPC_BRANCH   = 2'd1,
        NPC_JUMP_IMM = 2'd2,
        NPC_JUMP_REG = 2'd3
    } npc_op_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             valid
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = RAS_DEPTH[PW:0];
    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] sp;
    logic [PW:0] count;
    logic [PW-1:0] top_idx;
    logic replace;
    assign top_idx = sp - 1'b1;
    assign valid   = count != '0;
    assign top     = mem[top_idx];
    assign replace = push && pop && valid;
    always_ff @(posedge clk) begin
        if (replace)
            mem[top_idx] <= din;
        else if (push)
            mem[sp] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
        end else if (push && !replace) begin
            sp    <= sp + 1'b1;
            count <= count == FULL ? count : count + 1'b1;
        end else if (pop && !push && valid) begin
            sp    <= top_idx;
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: program counter with branch/jump targets, exception entry/return and a return-address stack
module pc_gen
    import ctrl_encode_def::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       npc_op,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_imm26,
    input  logic [WIDTH-1:0] addr,
    input  logic             is_call,
    input  logic             is_ret,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] npc,
    output logic [WIDTH-1:0] epc,
    output logic             exc_taken,
    output logic             misalign,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid
);
    logic [WIDTH-1:0] id_plus4, br_tgt, jimm_tgt, target;
    logic exc_entry;
    npc_op_t op;
    assign op        = npc_op_t'(npc_op);
    assign id_plus4  = id_pc + WIDTH'(4);
    assign br_tgt    = id_plus4 + {{(WIDTH-18){id_imm16[15]}}, id_imm16, 2'b00};
    assign jimm_tgt  = {id_plus4[WIDTH-1:28], id_imm26, 2'b00};
    assign misalign  = op == NPC_JUMP_REG && addr[1:0] != 2'b00;
    assign exc_entry = exc || misalign;
    always_comb begin
        target = op == NPC_BRANCH   ? br_tgt :
                 op == NPC_JUMP_IMM ? jimm_tgt :
                 op == NPC_JUMP_REG ? addr : pc + WIDTH'(4);
        npc    = exc_entry ? EXC_VEC : eret ? epc : stall ? pc : target;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            epc       <= '0;
            exc_taken <= 1'b0;
        end else begin
            pc        <= npc;
            epc       <= exc_entry ? id_pc : epc;
            exc_taken <= exc_entry;
        end
    end
    pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk  (clk),
        .rst  (rst),
        .push (is_call && !stall && !exc_entry),
        .pop  (is_ret && !stall && !exc_entry),
        .din  (id_plus4),
        .top  (ras_top),
        .valid(ras_valid)
    );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenario tests for pc_gen
module tb_pc_gen;
    import ctrl_encode_def::*;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, is_call = 1'b0, is_ret = 1'b0, exc = 1'b0, eret = 1'b0;
    logic [1:0] npc_op = 2'd0;
    logic [31:0] id_pc = '0, addr = '0;
    logic [15:0] id_imm16 = '0;
    logic [25:0] id_imm26 = '0;
    logic [31:0] pc, npc, epc, ras_top;
    logic exc_taken, misalign, ras_valid;
    int errors = 0, checks = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op), .id_pc(id_pc),
        .id_imm16(id_imm16), .id_imm26(id_imm26), .addr(addr), .is_call(is_call),
        .is_ret(is_ret), .exc(exc), .eret(eret), .pc(pc), .npc(npc), .epc(epc),
        .exc_taken(exc_taken), .misalign(misalign), .ras_top(ras_top), .ras_valid(ras_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h3000); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp %h", epc, 32'h0); end
        checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL reset_exc_taken got %b exp 0", exc_taken); end
        checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL reset_ras_valid got %b exp 0", ras_valid); end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (pc !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL plus4_%0d got %h exp %h", i, pc, 32'h3000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_branch_jump();
        id_pc = 32'h3010; npc_op = NPC_BRANCH; id_imm16 = 16'hFFFE;
        #1;
        checks++; if (npc !== 32'h300C) begin errors++; $display("FAIL branch_npc got %h exp %h", npc, 32'h300C); end
        step();
        checks++; if (pc !== 32'h300C) begin errors++; $display("FAIL branch_pc got %h exp %h", pc, 32'h300C); end
        npc_op = NPC_JUMP_IMM; id_imm26 = 26'h0000C10;
        step();
        checks++; if (pc !== 32'h3040) begin errors++; $display("FAIL jump_imm_pc got %h exp %h", pc, 32'h3040); end
        npc_op = NPC_JUMP_REG; addr = 32'h3080; id_pc = 32'h3040;
        step();
        checks++; if (pc !== 32'h3080) begin errors++; $display("FAIL jump_reg_pc got %h exp %h", pc, 32'h3080); end
    endtask

    task automatic test_misalign();
        npc_op = NPC_JUMP_REG; addr = 32'h3022; id_pc = 32'h3040;
        #1;
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign got %b exp 1", misalign); end
        checks++; if (npc !== 32'h4180) begin errors++; $display("FAIL misalign_npc got %h exp %h", npc, 32'h4180); end
        step();
        checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL misalign_pc got %h exp %h", pc, 32'h4180); end
        checks++; if (epc !== 32'h3040) begin errors++; $display("FAIL misalign_epc got %h exp %h", epc, 32'h3040); end
        checks++; if (exc_taken !== 1'b1) begin errors++; $display("FAIL exc_taken_pulse got %b exp 1", exc_taken); end
        npc_op = NPC_PLUS4; addr = '0;
        step();
        checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL exc_taken_drop got %b exp 0", exc_taken); end
        checks++; if (pc !== 32'h4184) begin errors++; $display("FAIL post_exc_pc got %h exp %h", pc, 32'h4184); end
        eret = 1'b1; stall = 1'b1;
        step();
        eret = 1'b0; stall = 1'b0;
        checks++; if (pc !== 32'h3040) begin errors++; $display("FAIL eret_pc got %h exp %h", pc, 32'h3040); end
        checks++; if (epc !== 32'h3040) begin errors++; $display("FAIL eret_epc got %h exp %h", epc, 32'h3040); end
        eret = 1'b1; exc = 1'b1; id_pc = 32'h3100;
        step();
        eret = 1'b0; exc = 1'b0;
        checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL exc_over_eret_pc got %h exp %h", pc, 32'h4180); end
        checks++; if (epc !== 32'h3100) begin errors++; $display("FAIL exc_over_eret_epc got %h exp %h", epc, 32'h3100); end
    endtask

    task automatic test_stall();
        stall = 1'b1; exc = 1'b1; id_pc = 32'h5000; is_call = 1'b1;
        step();
        exc = 1'b0;
        checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL stall_exc_pc got %h exp %h", pc, 32'h4180); end
        checks++; if (epc !== 32'h5000) begin errors++; $display("FAIL stall_exc_epc got %h exp %h", epc, 32'h5000); end
        id_pc = 32'h0700;
        step();
        step();
        checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL stall_hold_pc got %h exp %h", pc, 32'h4180); end
        checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL stall_exc_taken got %b exp 0", exc_taken); end
        checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL stall_ras_valid got %b exp 0", ras_valid); end
        stall = 1'b0; is_call = 1'b0;
        step();
        checks++; if (pc !== 32'h4184) begin errors++; $display("FAIL stall_release_pc got %h exp %h", pc, 32'h4184); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_top [4];
        exp_top = '{32'h504, 32'h404, 32'h304, 32'h204};
        is_call = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            id_pc = 32'(i * 32'h100);
            step();
        end
        is_call = 1'b0; is_ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ras_valid !== 1'b1 || ras_top !== exp_top[i]) begin
                errors++; $display("FAIL ras_pop_%0d got %h/%b exp %h/1", i, ras_top, ras_valid, exp_top[i]);
            end
            step();
        end
        checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL ras_empty got %b exp 0", ras_valid); end
        step();
        is_ret = 1'b0;
        checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL ras_pop_empty got %b exp 0", ras_valid); end
    endtask

    task automatic test_back_to_back();
        is_call = 1'b1; id_pc = 32'h10;
        step();
        id_pc = 32'h20;
        step();
        is_ret = 1'b1; id_pc = 32'h600;
        step();
        is_call = 1'b0;
        checks++; if (ras_top !== 32'h604) begin errors++; $display("FAIL pushpop_top got %h exp %h", ras_top, 32'h604); end
        step();
        checks++; if (ras_valid !== 1'b1 || ras_top !== 32'h14) begin errors++; $display("FAIL pushpop_count got %h/%b exp 14/1", ras_top, ras_valid); end
        is_ret = 1'b0; is_call = 1'b1; id_pc = 32'h30;
        step();
        exc = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL async_rst_pc got %h exp %h", pc, 32'h3000); end
        checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL async_rst_ras got %b exp 0", ras_valid); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL async_rst_epc got %h exp 0", epc); end
        is_call = 1'b0; exc = 1'b0; id_pc = '0;
        step();
        rst = 1'b0;
        step();
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL post_rst_pc got %h exp %h", pc, 32'h3004); end
        checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL post_rst_ras got %b exp 0", ras_valid); end
    endtask

    initial begin
        test_reset();
        test_branch_jump();
        test_misalign();
        test_stall();
        test_ras_overflow();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters: WIDTH, default 32, PC/address width; RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2); RESET_PC, default 32'h0000_3000, PC after reset; EXC_VEC, default 32'h0000_4180, exception entry address.
REQ-002 clk  in  1  the single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 stall  in  1  hold PC and all state except exception/eret handling.
REQ-005 npc_op  in  2  next-PC operation: PLUS4 / BRANCH / JUMP_IMM / JUMP_REG.
REQ-006 id_pc  in  WIDTH  PC of the instruction in ID.
REQ-007 id_imm16  in  16  branch offset in words, sign-extended.
REQ-008 id_imm26  in  26  jump-immediate field.
REQ-009 addr  in  WIDTH  register jump target.
REQ-010 is_call  in  1  ID holds jal/jalr; push return address.
REQ-011 is_ret  in  1  ID holds jr $ra; pop return address.
REQ-012 exc  in  1  external exception request.
REQ-013 eret  in  1  return from exception.
REQ-014 pc  out  WIDTH  registered current PC.
REQ-015 npc  out  WIDTH  combinational next-PC value loaded at the next edge.
REQ-016 epc  out  WIDTH  registered exception PC.
REQ-017 exc_taken  out  1  one-cycle pulse: exception entry loaded this edge.
REQ-018 misalign  out  1  combinational: JUMP_REG target with addr[1:0]!=0.
REQ-019 ras_top  out  WIDTH  top RAS entry; ras_valid  out  1  RAS non-empty.

Function
REQ-020 Target arithmetic: PLUS4 = pc+4; BRANCH = id_pc+4+(sext(id_imm16)<<2); JUMP_IMM = {(id_pc+4)[WIDTH-1:28], id_imm26, 2'b00}; JUMP_REG = addr; all modulo 2^WIDTH.
REQ-021 Next-PC priority: exc or misalign -> EXC_VEC; else eret -> epc; else stall -> pc; else target per REQ-020.
REQ-022 Latency: pc takes npc at the rising edge after the inputs are presented.
REQ-023 Exception entry (exc or misalign): epc <= id_pc; exc_taken = 1 for exactly that cycle; exception entry overrides stall.
REQ-024 eret with exc in the same cycle: exception wins, epc <= id_pc.
REQ-025 eret overrides stall; epc is unchanged by eret.
REQ-026 RAS push on is_call and not stall and no exception: entry <= id_pc+4.
REQ-027 RAS pop on is_ret and not stall and no exception: removes top entry; pop when empty is ignored.
REQ-028 Push when full: overwrites oldest entry (circular); count stays RAS_DEPTH.
REQ-029 Push and pop in the same cycle: top entry replaced by id_pc+4; count unchanged.
REQ-030 ras_valid = (count != 0); ras_top is don't-care when ras_valid = 0.
REQ-031 Wrap-around: pc+4 at 2^WIDTH-4 gives 0; no flag raised.

Reset
REQ-032 On rst: pc = RESET_PC, epc = 0, exc_taken = 0, RAS count = 0, ras_valid = 0; takes effect immediately, independent of clk.
REQ-033 Reset asserted mid-operation discards pending push/pop/exception; first edge after release loads npc computed from RESET_PC.

Structure
REQ-034 npc_op encodings (NPC_PLUS4=0, NPC_BRANCH=1, NPC_JUMP_IMM=2, NPC_JUMP_REG=3) reside in shared ctrl_encode_def; no local redefinition.
REQ-035 The RAS is a sub-module pc_ras (params WIDTH, RAS_DEPTH; ports clk, rst, push, pop, din, top, valid).

Verification
REQ-036 rst release, npc_op=PLUS4 for 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-037 id_pc=0x3010, BRANCH, id_imm16=0xFFFE -> pc = 0x300C next edge; JUMP_IMM id_imm26=0x0000C10 -> pc = 0x3040.
REQ-038 JUMP_REG addr=0x3022 -> misalign=1, pc = 0x4180, epc = id_pc, exc_taken pulses once; then eret -> pc = epc.
REQ-039 stall=1 with exc=1 -> pc = 0x4180; stall=1 alone for 2 cycles -> pc held, no RAS change.
REQ-040 5 calls with id_pc = 0x100,0x200,0x300,0x400,0x500 (depth 4) -> 4 pops return 0x504,0x404,0x304,0x204; 5th pop leaves ras_valid=0.
REQ-041 Simultaneous is_call/is_ret with id_pc=0x600 on 2-deep RAS -> top = 0x604, count 2; rst asserted between edges clears RAS and pc = 0x3000 immediately.
